mem_wb_stage: RTL and testbench

- MEM/WB pipeline register plus write-back select for the 5-stage RV32I core.
- Captures MEM-stage outputs (memory data, ALU result, rd, control) each cycle and drives the register-file write port.
- Also drives the WB-stage forwarding source for the hazard unit.
- Sits directly downstream of the MEM stage. Holds on stall, bubbles on flush, suppresses writes to x0.

---
 rtl/rv_pkg.sv | 33 +++
 rtl/mem_wb_stage_if.sv | 46 ++++
 rtl/pipe_reg.sv | 30 +++
 rtl/mem_wb_stage.sv | 77 +++++++
 tb/tb_mem_wb_stage.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I pipeline registers.
//
// Contents:
//   XLEN, REG_AW, NOP_INSTR  - datapath width, register address width, bubble opcode
//   mem_wb_t                 - packed MEM/WB register contents
//   MEM_WB_BUBBLE            - value loaded on reset and on flush (addi x0,x0,0, invalid)
package rv_pkg;

  localparam int          XLEN      = 32;
  localparam int          REG_AW    = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]   data;
    logic [XLEN-1:0]   alu_result;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              regout;
    logic [31:0]       instruction;
    logic              valid;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_BUBBLE = '{
    data:        '0,
    alu_result:  '0,
    rd:          '0,
    reg_write:   1'b0,
    regout:      1'b0,
    instruction: NOP_INSTR,
    valid:       1'b0
  };

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB bundle plus the register-file write port and WB forwarding source.
//
// Slot semantics: mem_valid marks a real instruction in the MEM slot (0 = bubble).
// There is no ready signal; stall is the only backpressure and, when high, the
// WB register holds and the MEM stage must keep its own contents. flush wins
// over stall and turns the WB slot into a bubble.
//
// Modports:
//   master - MEM stage / hazard unit side: drives mem_*, stall, flush; sees wb_*, fwd_*
//   slave  - mem_wb_stage side: receives mem_*, stall, flush; drives wb_*, fwd_*
interface mem_wb_stage_if;
  import rv_pkg::*;

  logic [XLEN-1:0]   mem_data;
  logic [XLEN-1:0]   mem_alu_result;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_reg_write;
  logic              mem_regout;
  logic [31:0]       mem_instruction;
  logic              mem_valid;
  logic              stall;
  logic              flush;

  logic [XLEN-1:0]   wb_write_data;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_reg_write;
  logic [31:0]       wb_instruction;
  logic              wb_valid;
  logic [XLEN-1:0]   fwd_wb_data;
  logic [REG_AW-1:0] fwd_wb_rd;

  modport master (
    output mem_data, mem_alu_result, mem_rd, mem_reg_write, mem_regout,
           mem_instruction, mem_valid, stall, flush,
    input  wb_write_data, wb_rd, wb_reg_write, wb_instruction, wb_valid,
           fwd_wb_data, fwd_wb_rd
  );

  modport slave (
    input  mem_data, mem_alu_result, mem_rd, mem_reg_write, mem_regout,
           mem_instruction, mem_valid, stall, flush,
    output wb_write_data, wb_rd, wb_reg_write, wb_instruction, wb_valid,
           fwd_wb_data, fwd_wb_rd
  );

endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register: async reset and flush both load RST_VAL,
// stall holds, otherwise d is captured. Priority: rst > flush > stall > load.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   stall, flush - hold / load-bubble controls
//   d, q         - W-bit data in / registered data out
module pipe_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (flush) begin
      q <= RST_VAL;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back select for the 5-stage RV32I core.
// Drives the register-file write port and the WB forwarding source. Outputs are
// functions of the registered fields only (1-cycle latency from mem_* inputs).
//
// Ports:
//   clk, rst     - core clock, asynchronous active-high reset
//   bus          - mem_wb_stage_if.slave: mem_* inputs, stall/flush, wb_*/fwd_* outputs
//   retire_count - 64-bit retired-instruction count (only with RETIRE_CNT_EN)
//
// Build option: define RETIRE_CNT_EN to add the retire counter and its port.
module mem_wb_stage
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mem_wb_stage_if.slave     bus
`ifdef RETIRE_CNT_EN
  ,
  output logic [63:0]       retire_count
`endif
);

  mem_wb_t                     d;
  mem_wb_t                     q;
  logic [$bits(mem_wb_t)-1:0]  q_bits;
  logic                        write_en;

  always_comb begin
    d             = MEM_WB_BUBBLE;
    d.data        = bus.mem_data;
    d.alu_result  = bus.mem_alu_result;
    d.rd          = bus.mem_rd;
    d.reg_write   = bus.mem_reg_write;
    d.regout      = bus.mem_regout;
    d.instruction = bus.mem_instruction;
    d.valid       = bus.mem_valid;
  end

  pipe_reg #(
    .W       ($bits(mem_wb_t)),
    .RST_VAL (MEM_WB_BUBBLE)
  ) u_reg (
    .clk   (clk),
    .rst   (rst),
    .stall (bus.stall),
    .flush (bus.flush),
    .d     (d),
    .q     (q_bits)
  );

  assign q = mem_wb_t'(q_bits);

  // Bubbles and x0 never write, whatever reg_write was captured.
  assign write_en = q.reg_write && q.valid && (q.rd != '0);

  assign bus.wb_write_data  = q.regout ? q.data : q.alu_result;
  assign bus.wb_rd          = q.rd;
  assign bus.wb_reg_write   = write_en;
  assign bus.wb_instruction = q.instruction;
  assign bus.wb_valid       = q.valid;
  assign bus.fwd_wb_data    = bus.wb_write_data;
  // Zero address tells the hazard unit there is nothing to forward.
  assign bus.fwd_wb_rd      = write_en ? q.rd : '0;

`ifdef RETIRE_CNT_EN
  // An instruction retires on the edge it leaves WB: either replaced by the
  // next one (not stalled) or squashed by a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_count <= '0;
    end else if (q.valid && (bus.flush || !bus.stall)) begin
      retire_count <= retire_count + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  mem_wb_stage_if bus ();

`ifdef RETIRE_CNT_EN
  logic [63:0] retire_count;
  logic [63:0] exp_ret;
`endif

  mem_wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef RETIRE_CNT_EN
    ,
    .retire_count (retire_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Holds the transaction currently sitting in WB, as the spec describes it.
  logic [31:0] m_data, m_alu, m_inst;
  logic [4:0]  m_rd;
  logic        m_rw, m_ro, m_v;

  task automatic model_bubble();
    m_data = 0; m_alu = 0; m_rd = 0; m_rw = 0; m_ro = 0; m_v = 0;
    m_inst = 32'h0000_0013;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic        e_rw;
    logic [31:0] e_wd;
    e_wd = m_ro ? m_data : m_alu;
    e_rw = m_rw && m_v && (m_rd != 0);
    check({tag, ".wd"},    bus.wb_write_data,  e_wd);
    check({tag, ".rd"},    bus.wb_rd,          m_rd);
    check({tag, ".rw"},    bus.wb_reg_write,   e_rw);
    check({tag, ".inst"},  bus.wb_instruction, m_inst);
    check({tag, ".valid"}, bus.wb_valid,       m_v);
    check({tag, ".fwdd"},  bus.fwd_wb_data,    e_wd);
    check({tag, ".fwdrd"}, bus.fwd_wb_rd,      e_rw ? m_rd : 5'd0);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [31:0] data, input logic [31:0] alu, input logic [4:0] rd,
                       input logic rw, input logic ro, input logic [31:0] inst,
                       input logic v, input logic s, input logic f);
    bus.mem_data        = data;
    bus.mem_alu_result  = alu;
    bus.mem_rd          = rd;
    bus.mem_reg_write   = rw;
    bus.mem_regout      = ro;
    bus.mem_instruction = inst;
    bus.mem_valid       = v;
    bus.stall           = s;
    bus.flush           = f;
  endtask

  // One clock with the currently driven inputs; the model advances alongside.
  task automatic cycle(input string tag);
`ifdef RETIRE_CNT_EN
    if (m_v && (bus.flush || !bus.stall)) exp_ret = exp_ret + 64'd1;
`endif
    if (bus.flush) begin
      model_bubble();
    end else if (!bus.stall) begin
      m_data = bus.mem_data; m_alu = bus.mem_alu_result; m_rd = bus.mem_rd;
      m_rw = bus.mem_reg_write; m_ro = bus.mem_regout; m_inst = bus.mem_instruction;
      m_v = bus.mem_valid;
    end
    @(posedge clk);
    #1;
    check_model(tag);
`ifdef RETIRE_CNT_EN
    check({tag, ".ret"}, retire_count, exp_ret);
`endif
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] data, alu;
    logic [4:0]  rd;
    logic        rw, ro;
    logic [31:0] inst;
    logic        v, s, f;
    logic [31:0] e_wd;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic [31:0] e_inst;
    logic        e_v;
    logic [4:0]  e_fwd;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic [31:0] data, logic [31:0] alu, logic [4:0] rd, logic rw,
                              logic ro, logic [31:0] inst, logic v, logic s, logic f,
                              logic [31:0] e_wd, logic [4:0] e_rd, logic e_rw,
                              logic [31:0] e_inst, logic e_v, logic [4:0] e_fwd);
    vec_t r;
    r.data = data; r.alu = alu; r.rd = rd; r.rw = rw; r.ro = ro; r.inst = inst;
    r.v = v; r.s = s; r.f = f; r.e_wd = e_wd; r.e_rd = e_rd; r.e_rw = e_rw;
    r.e_inst = e_inst; r.e_v = e_v; r.e_fwd = e_fwd;
    return r;
  endfunction

  initial begin
    tests  = 0;
    failed = 0;
`ifdef RETIRE_CNT_EN
    exp_ret = 0;
`endif
    model_bubble();
    drive(0, 0, 0, 0, 0, 32'h0000_0013, 0, 0, 0);
    rst = 1'b1;
    #2;
    check("reset.wd",    bus.wb_write_data,  32'd0);
    check("reset.rd",    bus.wb_rd,          5'd0);
    check("reset.rw",    bus.wb_reg_write,   1'b0);
    check("reset.inst",  bus.wb_instruction, 32'h0000_0013);
    check("reset.valid", bus.wb_valid,       1'b0);
    check("reset.fwdrd", bus.fwd_wb_rd,      5'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    //              data          alu           rd  rw ro inst          v  s  f   e_wd          e_rd e_rw e_inst        e_v e_fwd
    vecs[0]  = mk(32'h0,        32'hAA,       5,  1, 0, 32'h00A00293, 1, 0, 0,  32'hAA,       5,   1,   32'h00A00293, 1,  5);
    vecs[1]  = mk(32'hDEADBEEF, 32'h1234,     7,  1, 1, 32'h0002A383, 1, 0, 0,  32'hDEADBEEF, 7,   1,   32'h0002A383, 1,  7);
    vecs[2]  = mk(32'hDEADBEEF, 32'h1234,     7,  1, 0, 32'h12300393, 1, 0, 0,  32'h1234,     7,   1,   32'h12300393, 1,  7);
    vecs[3]  = mk(32'h0,        32'h55,       0,  1, 0, 32'h05500013, 1, 0, 0,  32'h55,       0,   0,   32'h05500013, 1,  0);
    vecs[4]  = mk(32'h0,        32'h66,       3,  1, 0, 32'h06600193, 0, 0, 0,  32'h66,       3,   0,   32'h06600193, 0,  0);
    vecs[5]  = mk(32'h0,        32'h99,       9,  1, 0, 32'h09900493, 1, 0, 0,  32'h99,       9,   1,   32'h09900493, 1,  9);
    vecs[6]  = mk(32'h0,        32'h11,       2,  1, 0, 32'h01100113, 1, 1, 0,  32'h99,       9,   1,   32'h09900493, 1,  9);
    vecs[7]  = mk(32'h0,        32'h22,       4,  1, 0, 32'h02200213, 1, 1, 0,  32'h99,       9,   1,   32'h09900493, 1,  9);
    vecs[8]  = mk(32'h44,       32'h33,       6,  1, 1, 32'h03300313, 1, 1, 0,  32'h99,       9,   1,   32'h09900493, 1,  9);
    vecs[9]  = mk(32'h0,        32'h77,       10, 1, 0, 32'h07700513, 1, 1, 1,  32'h0,        0,   0,   32'h00000013, 0,  0);
    vecs[10] = mk(32'h0,        32'h88,       11, 1, 0, 32'h08800593, 1, 0, 1,  32'h0,        0,   0,   32'h00000013, 0,  0);
    vecs[11] = mk(32'h0,        32'h77,       8,  0, 0, 32'h07700413, 1, 0, 0,  32'h77,       8,   0,   32'h07700413, 1,  0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].data, vecs[i].alu, vecs[i].rd, vecs[i].rw, vecs[i].ro, vecs[i].inst,
            vecs[i].v, vecs[i].s, vecs[i].f);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.wd", i),    bus.wb_write_data,  vecs[i].e_wd);
      check($sformatf("vec%0d.rd", i),    bus.wb_rd,          vecs[i].e_rd);
      check($sformatf("vec%0d.rw", i),    bus.wb_reg_write,   vecs[i].e_rw);
      check($sformatf("vec%0d.inst", i),  bus.wb_instruction, vecs[i].e_inst);
      check($sformatf("vec%0d.valid", i), bus.wb_valid,       vecs[i].e_v);
      check($sformatf("vec%0d.fwdrd", i), bus.fwd_wb_rd,      vecs[i].e_fwd);
      check($sformatf("vec%0d.fwdd", i),  bus.fwd_wb_data,    vecs[i].e_wd);
    end

    // Async reset between edges with a valid write held in WB.
    drive(32'h0, 32'hCAFE, 5, 1, 0, 32'h00500293, 1, 0, 0);
    @(posedge clk);
    #1;
    check("prerst.rw", bus.wb_reg_write, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("midrst.rw",    bus.wb_reg_write,   1'b0);
    check("midrst.rd",    bus.wb_rd,          5'd0);
    check("midrst.inst",  bus.wb_instruction, 32'h0000_0013);
    check("midrst.valid", bus.wb_valid,       1'b0);
    check("midrst.wd",    bus.wb_write_data,  32'd0);
    // Release reset while stalled: the next edge holds the bubble.
    bus.stall = 1'b1;
    #1 rst = 1'b0;
    model_bubble();
`ifdef RETIRE_CNT_EN
    exp_ret = 0;
`endif
    cycle("rststall");
    bus.stall = 1'b0;
    cycle("rstrel");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom, $urandom, 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 31)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 9) == 0));
      cycle("rand");
    end

`ifdef RETIRE_CNT_EN
    // 10 valid instructions, 2 stall cycles, 1 bubble.
    rst = 1'b1;
    #1 rst = 1'b0;
    model_bubble();
    exp_ret = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 32'(i), 5'(i + 1), 1, 0, 32'h13 + 32'(i << 7), 1, 0, 0);
      cycle("ret.load");
    end
    bus.stall = 1'b1;
    cycle("ret.stall");
    cycle("ret.stall");
    drive(0, 0, 0, 0, 0, 32'h13, 0, 0, 0);
    cycle("ret.bubble");
    cycle("ret.idle");
    check("ret.ten", retire_count, 64'd10);

    // Wrap from all ones.
    force dut.retire_count = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.retire_count;
    exp_ret = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(0, 32'h5, 5'd3, 1, 0, 32'h00500193, 1, 0, 0);
    cycle("ret.pre");
    cycle("ret.wrap");
    check("ret.zero", retire_count, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
